// File: rtl/bomb_pkg.sv
// Purpose : shared types and constants for the bomb stage and the round referee.
// Latency : n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package bomb_pkg;

  // Published round result; the renderer and score display decode these codes.
  typedef enum logic [1:0] {
    NOT_OVER  = 2'd0,
    GAME_OVER = 2'd1,   // both players dead: draw
    P1_WIN    = 2'd2,
    P2_WIN    = 2'd3
  } game_status_t;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
  } ref_state_t;

  // Tile codes written by the bomb stage. Any code >= EXP_H means the tile
  // is burning; the bomb stage reduces that to one explode bit per tile.
  localparam logic [2:0] EMPTY   = 3'd0;
  localparam logic [2:0] WALL    = 3'd1;
  localparam logic [2:0] BOMB    = 3'd2;
  localparam logic [2:0] EXP_H   = 3'd3;
  localparam logic [2:0] EXP_V   = 3'd4;
  localparam logic [2:0] EXP_CEN = 3'd5;

  localparam int GRID_W  = 16;
  localparam int N_TILES = GRID_W * GRID_W;

  // Result frozen on OVER entry. Neither dead cannot occur on that path,
  // but NOT_OVER is the harmless answer if it ever did.
  function automatic game_status_t final_status(input logic p1_dead, input logic p2_dead);
    if (p1_dead && p2_dead) return GAME_OVER;
    if (p2_dead)            return P1_WIN;
    if (p1_dead)            return P2_WIN;
    return NOT_OVER;
  endfunction

endpackage

// File: rtl/game_referee_if.sv
// Purpose : bundle between the bomb stage / bench (master) and the referee (slave).
// Latency : n/a (wiring only).
// Backpressure: none; every signal is sampled or produced once per frame.
//  explode     m->s 256  burning-tile map, tile = row*16+col
//  p1/p2_cor   m->s 8    player tile indices
//  restart     m->s 1    level, honoured only in OVER
//  game_status s->m 2    registered round result
//  p1/p2_lives s->m 2    lives remaining
//  p1/p2_hit   s->m 1    one-cycle pulse after a life is lost
//  p1/p2_blink s->m 1    sprite-hide strobe while invulnerable
interface game_referee_if;
  import bomb_pkg::*;

  logic [N_TILES-1:0] explode;
  logic [7:0]         p1_cor;
  logic [7:0]         p2_cor;
  logic               restart;
  game_status_t       game_status;
  logic [1:0]         p1_lives;
  logic [1:0]         p2_lives;
  logic               p1_hit;
  logic               p2_hit;
  logic               p1_blink;
  logic               p2_blink;

  modport master (
    output explode, p1_cor, p2_cor, restart,
    input  game_status, p1_lives, p2_lives, p1_hit, p2_hit, p1_blink, p2_blink
  );

  modport slave (
    input  explode, p1_cor, p2_cor, restart,
    output game_status, p1_lives, p2_lives, p1_hit, p2_hit, p1_blink, p2_blink
  );

endinterface

// File: rtl/player_health.sv
// Purpose : one player's lives, post-hit invulnerability counter, hit pulse and blink strobe.
// Latency : 1 cycle from a burning tile to lives/hit; blink follows the counter combinationally.
// Backpressure: none; a hit is taken whenever the player is vulnerable and standing in fire.
//  clk, reset  clock, async active-high reset
//  burn        player's tile is burning this cycle
//  enable      round is live (not OVER); when low, no hits and the counter freezes
//  reload      restart the round: lives back to LIVES, counter cleared
//  lives       lives remaining (saturates at 0)
//  hit         one-cycle pulse on the cycle after a life is lost
//  blink       sprite-hide strobe, toggles every 4 cycles while invulnerable
module player_health #(
  parameter int LIVES         = 3,
  parameter int INVULN_CYCLES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       burn,
  input  logic       enable,
  input  logic       reload,
  output logic [1:0] lives,
  output logic       hit,
  output logic       blink
);

  logic [1:0] r_lives;
  logic [7:0] r_inv_ctr;
  logic       r_hit;
  logic       w_take_hit;

  // lives!=0 makes the decrement saturate; inv_ctr==0 is the invulnerability gate.
  assign w_take_hit = burn && (r_inv_ctr == 8'd0) && (r_lives != 2'd0) && enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lives   <= 2'(LIVES);
      r_inv_ctr <= 8'd0;
      r_hit     <= 1'b0;
    end else if (reload) begin
      r_lives   <= 2'(LIVES);
      r_inv_ctr <= 8'd0;
      r_hit     <= 1'b0;
    end else if (w_take_hit) begin
      r_lives   <= r_lives - 2'd1;
      r_inv_ctr <= 8'(INVULN_CYCLES);
      r_hit     <= 1'b1;
    end else begin
      r_hit <= 1'b0;
      // Counter holds while the round is frozen in OVER.
      if (enable && (r_inv_ctr != 8'd0)) r_inv_ctr <= r_inv_ctr - 8'd1;
    end
  end

  assign lives = r_lives;
  assign hit   = r_hit;
  assign blink = (r_inv_ctr != 8'd0) && r_inv_ctr[2];

endmodule

// File: rtl/game_referee.sv
// Purpose : samples the explode map at both player tiles, tracks damage and runs the round FSM.
// Latency : 1 cycle fire->lives/hit; OVER result appears DEATH_HOLD+1 cycles after a player's lives reach 0.
// Backpressure: none; one evaluation per frame, restart is a level honoured only in OVER.
//  clk    system clock, one cycle per frame
//  reset  asynchronous, active-high; clears all state
//  bus    game_referee_if slave: explode/p1_cor/p2_cor/restart in, status/lives/hit/blink out
module game_referee
  import bomb_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int INVULN_CYCLES = 60,
  parameter int DEATH_HOLD    = 30
) (
  input  logic           clk,
  input  logic           reset,
  game_referee_if.slave  bus
);

  ref_state_t   r_state;
  logic [7:0]   r_hold_ctr;
  game_status_t r_status;

  logic       w_p1_burn;
  logic       w_p2_burn;
  logic       w_enable;
  logic       w_reload;
  logic [1:0] w_p1_lives;
  logic [1:0] w_p2_lives;

  // 256:1 muxes; the two players are evaluated independently, even on the same tile.
  assign w_p1_burn = bus.explode[bus.p1_cor];
  assign w_p2_burn = bus.explode[bus.p2_cor];

  // Hits stay live through DYING so the survivor can still be caught.
  assign w_enable = (r_state != OVER);
  assign w_reload = (r_state == OVER) && bus.restart;

  player_health #(
    .LIVES         (LIVES),
    .INVULN_CYCLES (INVULN_CYCLES)
  ) u_p1 (
    .clk    (clk),
    .reset  (reset),
    .burn   (w_p1_burn),
    .enable (w_enable),
    .reload (w_reload),
    .lives  (w_p1_lives),
    .hit    (bus.p1_hit),
    .blink  (bus.p1_blink)
  );

  player_health #(
    .LIVES         (LIVES),
    .INVULN_CYCLES (INVULN_CYCLES)
  ) u_p2 (
    .clk    (clk),
    .reset  (reset),
    .burn   (w_p2_burn),
    .enable (w_enable),
    .reload (w_reload),
    .lives  (w_p2_lives),
    .hit    (bus.p2_hit),
    .blink  (bus.p2_blink)
  );

  // Death is detected on the registered lives, so DYING starts the cycle after the fatal hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= PLAY;
      r_hold_ctr <= 8'd0;
      r_status   <= NOT_OVER;
    end else begin
      case (r_state)
        PLAY: begin
          if ((w_p1_lives == 2'd0) || (w_p2_lives == 2'd0)) begin
            r_state    <= DYING;
            r_hold_ctr <= 8'(DEATH_HOLD - 1);
          end
        end
        DYING: begin
          if (r_hold_ctr == 8'd0) begin
            r_state  <= OVER;
            r_status <= final_status(w_p1_lives == 2'd0, w_p2_lives == 2'd0);
          end else begin
            r_hold_ctr <= r_hold_ctr - 8'd1;
          end
        end
        OVER: begin
          if (bus.restart) begin
            r_state  <= PLAY;
            r_status <= NOT_OVER;
          end
        end
        default: begin
          r_state  <= PLAY;
          r_status <= NOT_OVER;
        end
      endcase
    end
  end

  assign bus.game_status = r_status;
  assign bus.p1_lives    = w_p1_lives;
  assign bus.p2_lives    = w_p2_lives;

endmodule
